pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Next-PC sequencer for the multicycle MIPS core; it consumes the 18-bit offset produced by the immediate-extension stage.
- The control FSM issues one request per instruction (sequential, conditional branch or jump).
- The block computes the target over a fixed 3-edge handshake and commits it to the architectural PC.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
PC_W, 32, PC width in bits (fixed at 32; other values not supported)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
req  input  1  request strobe from control FSM; sampled only in IDLE
op  input  2  2'b00 SEQ, 2'b01 BRANCH, 2'b10 JUMP, 2'b11 reserved
cond  input  1  branch condition (e.g. BGTZ compare result); used only for BRANCH
offset  input  18  offset from extension stage (already word-shifted for BRANCH/JUMP)
busy  output  1  high while a request is in flight
done  output  1  one-cycle pulse; new pc is valid in the same cycle
taken  output  1  1 if the last committed op redirected flow (BRANCH with cond=1, or JUMP)
pc  output  32  architectural PC
pc_plus4  output  32  registered pc+4

Behaviour:
- Reset (asynchronous; takes effect immediately and aborts any in-flight request):
  - pc=RESET_PC, pc_plus4=RESET_PC+4
  - busy=0, done=0, taken=0
  - state=IDLE; internal op, cond, offset and next_pc registers cleared
- States: IDLE -> CALC -> COMMIT -> IDLE.
- IDLE:
  - On a clock edge with req=1: latch op, cond and offset; go to CALC; busy=1.
  - req=0: remain in IDLE.
- CALC: compute next_pc from the latched op and register it; record the taken flag; go to COMMIT.
  - SEQ: pc_plus4
  - BRANCH, cond=1: pc_plus4 + {{14{offset[17]}}, offset}; taken=1
  - BRANCH, cond=0: pc_plus4; taken=0
  - JUMP: {pc_plus4[31:18], offset}; taken=1
  - op=2'b11: treated as SEQ; taken=0
- COMMIT, on the edge:
  - pc<=next_pc, pc_plus4<=next_pc+4, taken<=latched taken flag
  - done<=1 for exactly one cycle; busy<=0; state<=IDLE
- Latency: req sampled at edge E0; pc, pc_plus4, taken and done all update together at edge E2.
- Throughput: one request per 3 cycles. A req held high while done=1 is accepted at that edge (back-to-back operation).
- req and inputs while busy=1: ignored. op, cond and offset are used only as latched at E0, so later changes have no effect.
- Arithmetic: all adds are 32-bit modulo. pc=32'hFFFFFFFC with SEQ gives pc=0 and pc_plus4=4. Branch with a negative offset below 0 wraps the same way.
- pc, pc_plus4 and taken are stable between commits.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined: adds output misalign (1 bit, reset 0).
  - At COMMIT, if next_pc[1:0]!=2'b00: pc, pc_plus4 and taken are held unchanged, misalign pulses high together with done, and done still pulses.
  - misalign is 0 on every aligned commit.
- Not defined: no misalign port; next_pc is committed as computed, including low bits.

Test Plan:
1. Assert rst for 2 cycles, then release -> pc=0x0, pc_plus4=0x4, busy=0, done=0, taken=0.
2. Hold req=1 with op=SEQ continuously from reset -> done pulses every 3 cycles; pc steps 0x4, 0x8, 0xC; busy low only in each done cycle.
3. At pc=0xC: op=BRANCH, cond=1, offset=18'h3FFF8 -> pc=0x8, pc_plus4=0xC, taken=1 two edges after acceptance.
   Then op=BRANCH, cond=0, offset=18'h00040 -> pc=0xC, taken=0.
4. At pc=0xC: op=JUMP, offset=18'h00400 -> pc=0x00000400, taken=1.
   Then change op/offset during CALC -> result unaffected.
   Then with RESET_PC=32'hFFFFFFFC: SEQ -> pc=0x0, pc_plus4=0x4.
5. Accept a BRANCH, then assert rst while in CALC -> pc=RESET_PC immediately, busy=0, and no done pulse ever follows.
6. With PC_ALIGN_CHECK_EN: at pc=0x0, BRANCH, cond=1, offset=18'h00002 -> misalign=1 and done=1 in the same cycle, pc stays 0x0.
   Without the macro, the same stimulus -> pc=0x6.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC sequencer with a fixed 3-edge request/commit handshake (optional PC_ALIGN_CHECK_EN)
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic [1:0]      op,
    input  logic            cond,
    input  logic [17:0]     offset,
    output logic            busy,
    output logic            done,
    output logic            taken,
`ifdef PC_ALIGN_CHECK_EN
    output logic            misalign,
`endif
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4
);

    localparam logic [1:0] OP_SEQ    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        COMMIT = 2'b10
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        op_q;
    logic              cond_q;
    logic [17:0]       offset_q;
    logic [PC_W-1:0]   next_pc;
    logic              taken_q;
    logic [PC_W-1:0]   calc_pc;
    logic              calc_taken;

    // State register; reset aborts any request in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one request walks IDLE -> CALC -> COMMIT -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = CALC;
            CALC:    state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Target computation from the latched request; reserved op falls back to sequential
    always_comb begin
        calc_pc    = pc_plus4;
        calc_taken = 1'b0;
        case (op_q)
            OP_SEQ: begin
                calc_pc    = pc_plus4;
                calc_taken = 1'b0;
            end
            OP_BRANCH: begin
                if (cond_q) begin
                    calc_pc    = pc_plus4 + {{(PC_W-18){offset_q[17]}}, offset_q};
                    calc_taken = 1'b1;
                end
            end
            OP_JUMP: begin
                calc_pc    = {pc_plus4[PC_W-1:18], offset_q};
                calc_taken = 1'b1;
            end
            default: begin
                calc_pc    = pc_plus4;
                calc_taken = 1'b0;
            end
        endcase
    end

    // Request latch, target register and architectural PC commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= 2'b00;
            cond_q   <= 1'b0;
            offset_q <= 18'd0;
            next_pc  <= '0;
            taken_q  <= 1'b0;
            pc       <= RESET_PC;
            pc_plus4 <= RESET_PC + 32'd4;
            taken    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        op_q     <= op;
                        cond_q   <= cond;
                        offset_q <= offset;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    next_pc <= calc_pc;
                    taken_q <= calc_taken;
                end
                COMMIT: begin
                    done <= 1'b1;
                    busy <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                    // A misaligned target leaves the architectural state untouched
                    if (next_pc[1:0] != 2'b00) begin
                        misalign <= 1'b1;
                    end else begin
                        pc       <= next_pc;
                        pc_plus4 <= next_pc + 32'd4;
                        taken    <= taken_q;
                    end
`else
                    pc       <= next_pc;
                    pc_plus4 <= next_pc + 32'd4;
                    taken    <= taken_q;
`endif
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized and directed bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        req;
    logic [1:0]  op;
    logic        cond;
    logic [17:0] offset;
    logic        busy, done, taken;
    logic [31:0] pc, pc_plus4;

    logic        req2;
    logic [1:0]  op2;
    logic        cond2;
    logic [17:0] offset2;
    logic        busy2, done2, taken2;
    logic [31:0] pc2, pc2_plus4;

`ifdef PC_ALIGN_CHECK_EN
    logic        misalign, misalign2;
`endif

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.RESET_PC(32'h00000000), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .cond(cond), .offset(offset),
        .busy(busy), .done(done), .taken(taken),
`ifdef PC_ALIGN_CHECK_EN
        .misalign(misalign),
`endif
        .pc(pc), .pc_plus4(pc_plus4)
    );

    pc_sequencer #(.RESET_PC(32'hFFFFFFFC), .PC_W(32)) dut_wrap (
        .clk(clk), .rst(rst), .req(req2), .op(op2), .cond(cond2), .offset(offset2),
        .busy(busy2), .done(done2), .taken(taken2),
`ifdef PC_ALIGN_CHECK_EN
        .misalign(misalign2),
`endif
        .pc(pc2), .pc_plus4(pc2_plus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a request accepted at an edge lands two edges later
    int          m_age;
    logic [31:0] m_pc;
    logic        m_taken, m_done, m_busy, m_mis;
    logic [1:0]  l_op;
    logic        l_cond;
    logic [17:0] l_off;

    always @(posedge clk or posedge rst) begin
        logic [31:0] tgt;
        logic        tk;
        int          soff;
        if (rst) begin
            m_age = 0; m_pc = 32'h0; m_taken = 0; m_done = 0; m_busy = 0; m_mis = 0;
        end else begin
            m_done = 0;
            m_mis  = 0;
            if (m_age == 0) begin
                if (req) begin
                    l_op = op; l_cond = cond; l_off = offset;
                    m_age = 1; m_busy = 1;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else begin
                soff = l_off[17] ? int'(l_off) - 262144 : int'(l_off);
                tgt  = m_pc + 32'd4;
                tk   = 0;
                if (l_op == 2'd1 && l_cond) begin
                    tgt = m_pc + 32'd4 + soff;
                    tk  = 1;
                end else if (l_op == 2'd2) begin
                    tgt = ((m_pc + 32'd4) & 32'hFFFC0000) | {14'd0, l_off};
                    tk  = 1;
                end
`ifdef PC_ALIGN_CHECK_EN
                if (tgt % 4 != 0) begin
                    m_mis = 1;
                end else begin
                    m_pc = tgt; m_taken = tk;
                end
`else
                m_pc = tgt; m_taken = tk;
`endif
                m_done = 1; m_busy = 0; m_age = 0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("taken", {31'd0, taken}, {31'd0, m_taken});
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
`ifdef PC_ALIGN_CHECK_EN
            chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
`endif
        end
    end

    task automatic wait_done(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout actual=no_done expected=done", name);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic c, input logic [17:0] off, input string name);
        req = 1; op = o; cond = c; offset = off;
        @(posedge clk);
        #1;
        req    = 0;
        op     = 2'($urandom);
        cond   = 1'($urandom);
        offset = 18'($urandom);
        wait_done(name);
    endtask

    initial begin
        rst = 1; req = 1; op = 2'b00; cond = 0; offset = 18'd0;
        req2 = 1; op2 = 2'b00; cond2 = 0; offset2 = 18'd0;

        // Reset, then release with a sequential request already held
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_pc", pc, 32'h0);
        chk("reset_pc_plus4", pc_plus4, 32'h4);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_taken", {31'd0, taken}, 32'd0);

        wait_done("seq1");
        chk("seq1_pc", pc, 32'h4);
        chk("seq1_busy_low", {31'd0, busy}, 32'd0);
        chk("wrap_pc", pc2, 32'h0);
        chk("wrap_pc_plus4", pc2_plus4, 32'h4);
        chk("wrap_done", {31'd0, done2}, 32'd1);
        req2 = 0;
        wait_done("seq2");
        chk("seq2_pc", pc, 32'h8);
        wait_done("seq3");
        chk("seq3_pc", pc, 32'hC);
        req = 0;

        // Branches and jump; inputs are scrambled after acceptance
        issue(2'b01, 1'b1, 18'h3FFF8, "br_taken");
        chk("br_taken_pc", pc, 32'h8);
        chk("br_taken_pc_plus4", pc_plus4, 32'hC);
        chk("br_taken_taken", {31'd0, taken}, 32'd1);
        issue(2'b01, 1'b0, 18'h00040, "br_not");
        chk("br_not_pc", pc, 32'hC);
        chk("br_not_taken", {31'd0, taken}, 32'd0);
        issue(2'b10, 1'b0, 18'h00400, "jump");
        chk("jump_pc", pc, 32'h00000400);
        chk("jump_taken", {31'd0, taken}, 32'd1);

        // Reset while in CALC aborts the request
        req = 1; op = 2'b01; cond = 1; offset = 18'h00010;
        @(posedge clk);
        #1 req = 0; rst = 1;
        #1;
        chk("abort_pc", pc, 32'h0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end

        // Misaligned branch target
        req = 1; op = 2'b01; cond = 1; offset = 18'h00002;
        @(posedge clk);
        #1 req = 0;
        wait_done("misalign");
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_pc_held", pc, 32'h0);
`else
        chk("mis_pc", pc, 32'h6);
        chk("mis_taken", {31'd0, taken}, 32'd1);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            rst    = ($urandom_range(0, 149) == 0);
            req    = 1'($urandom);
            op     = 2'($urandom);
            cond   = 1'($urandom);
            offset = ($urandom_range(0, 3) == 0) ? 18'($urandom) : {16'($urandom), 2'b00};
        end
        @(posedge clk);
        #1 rst = 0; req = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
